// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester-side request/response bundle for the data RAM arbiter
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, is_unsigned, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, is_unsigned, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port word RAM
module dmem_arbiter #(
    parameter int ADDR_W  = 15,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    logic        r_rr;
    logic        r_valid;
    logic        r_owner;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic        r_err;

    logic        w_gnt0, w_gnt1, w_any, w_sel;
    logic        w_we, w_uns, w_mis;
    logic [1:0]  w_size, w_off;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_lanes;
    logic [31:0] w_lane_data;
    logic [31:0] w_shift, w_fmt, w_resp;
    logic        w_unused;

    // r_rr = 0 favours port 0 when both request
    assign w_gnt0 = rst_n & m0.req & (~m1.req | ~r_rr);
    assign w_gnt1 = rst_n & m1.req & (~m0.req |  r_rr);
    assign w_any  = w_gnt0 | w_gnt1;
    assign w_sel  = w_gnt1;

    assign m0.gnt = w_gnt0;
    assign m1.gnt = w_gnt1;

    assign w_we    = w_sel ? m1.we          : m0.we;
    assign w_size  = w_sel ? m1.size        : m0.size;
    assign w_uns   = w_sel ? m1.is_unsigned : m0.is_unsigned;
    assign w_addr  = w_sel ? m1.addr        : m0.addr;
    assign w_wdata = w_sel ? m1.wdata       : m0.wdata;
    assign w_off   = w_addr[1:0];

    always_comb begin
        w_mis       = 1'b0;
        w_lanes     = 4'hF;
        w_lane_data = w_wdata;
        case (w_size)
            2'd0: begin
                w_lanes     = 4'b0001 << w_off;
                w_lane_data = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_mis       = w_off[0];
                w_lanes     = 4'b0011 << w_off;
                w_lane_data = {2{w_wdata[15:0]}};
            end
            default: w_mis = |w_off;
        endcase
    end

    // Misaligned requests are granted but never touch the RAM
    assign mem_en    = w_any & ~w_mis;
    assign mem_we    = (mem_en & w_we) ? w_lanes : 4'h0;
    assign mem_addr  = w_addr[ADDR_W+1:2];
    assign mem_wdata = w_lane_data;
    assign w_unused  = &{1'b0, w_addr[31:ADDR_W+2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= RR_INIT;
            r_valid <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_off   <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            if (m0.req && m1.req)
                r_rr <= ~r_rr;
            r_valid <= w_any;
            r_owner <= w_sel;
            r_we    <= w_we;
            r_size  <= w_size;
            r_uns   <= w_uns;
            r_off   <= w_off;
            r_err   <= w_mis;
        end
    end

    assign w_shift = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_fmt = w_shift;
        case (r_size)
            2'd0:    w_fmt = r_uns ? {24'h0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_fmt = r_uns ? {16'h0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_fmt = w_shift;
        endcase
    end

    assign w_resp = (r_we | r_err) ? 32'h0 : w_fmt;

    assign m0.rvalid = r_valid & ~r_owner;
    assign m1.rvalid = r_valid &  r_owner;
    assign m0.rdata  = m0.rvalid ? w_resp : 32'h0;
    assign m1.rdata  = m1.rvalid ? w_resp : 32'h0;
    assign m0.err    = m0.rvalid & r_err;
    assign m1.err    = m1.rvalid & r_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a registered-read RAM model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter #(.ADDR_W(15), .RR_INIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:1023];
    logic [31:0] ram_q = 32'h0;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            ram_q <= ram[mem_addr[9:0]];
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    logic [1:0] gnts;
    assign gnts = {m1_if.gnt, m0_if.gnt};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every response strobe pops one expectation
    always @(negedge clk) begin
        if (rst_n && (m0_if.rvalid || m1_if.rvalid)) begin
            if (m0_if.rvalid && m1_if.rvalid) begin
                chk("dual_rvalid", {31'h0, m1_if.rvalid}, 32'h0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {31'h0, m0_if.rvalid | m1_if.rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_port", {31'h0, m1_if.rvalid}, {31'h0, e.port});
                chk("resp_rdata", m1_if.rvalid ? m1_if.rdata : m0_if.rdata, e.rdata);
                chk("resp_err", {31'h0, m1_if.rvalid ? m1_if.err : m0_if.err}, {31'h0, e.err});
            end
        end
    end

    task automatic set_req(input bit p, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            m1_if.req = 1'b1; m1_if.we = we; m1_if.size = size;
            m1_if.is_unsigned = uns; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = 1'b1; m0_if.we = we; m0_if.size = size;
            m0_if.is_unsigned = uns; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    task automatic push_exp(input bit p, input logic [31:0] rdata, input bit err);
        exp_t e;
        e.port = p; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input string name, input bit p, input bit we, input logic [1:0] size,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit x_en, input logic [3:0] x_we, input logic [31:0] x_wdata,
                          input logic [31:0] x_rdata, input bit x_err);
        bit got;
        got = 1'b0;
        set_req(p, we, size, uns, addr, wdata);
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = p ? m1_if.gnt : m0_if.gnt;
        end
        if (!got) begin
            chk({name, "_gnt_timeout"}, 32'h0, 32'h1);
        end else begin
            chk({name, "_mem_en"}, {31'h0, mem_en}, {31'h0, x_en});
            chk({name, "_mem_we"}, {28'h0, mem_we}, {28'h0, x_we});
            if (x_en) chk({name, "_mem_addr"}, {17'h0, mem_addr}, {17'h0, addr[16:2]});
            if (x_we != 4'h0) chk({name, "_mem_wdata"}, mem_wdata, x_wdata);
            push_exp(p, x_rdata, x_err);
        end
        @(posedge clk); #1;
        if (p) m1_if.req = 1'b0; else m0_if.req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.size = 2'd2; m0_if.is_unsigned = 1'b0;
        m0_if.addr = 32'h100; m0_if.wdata = 32'h0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.size = 2'd2; m1_if.is_unsigned = 1'b0;
        m1_if.addr = 32'h0; m1_if.wdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'h0, gnts}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_rvalid", {30'h0, m1_if.rvalid, m0_if.rvalid}, 32'h0);
        chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
        chk("rst_err", {30'h0, m1_if.err, m0_if.err}, 32'h0);
        m0_if.req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req("sw",   0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        do_req("lw",   0, 0, 2'd2, 0, 32'h100, 32'h0, 1, 4'h0, 32'h0, 32'hDEADBEEF, 0);
        do_req("lb",   0, 0, 2'd0, 0, 32'h103, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFFFDE, 0);
        do_req("lbu",  0, 0, 2'd0, 1, 32'h103, 32'h0, 1, 4'h0, 32'h0, 32'h000000DE, 0);
        do_req("lh",   0, 0, 2'd1, 0, 32'h102, 32'h0, 1, 4'h0, 32'h0, 32'hFFFFDEAD, 0);
        do_req("lhu",  0, 0, 2'd1, 1, 32'h100, 32'h0, 1, 4'h0, 32'h0, 32'h0000BEEF, 0);
        do_req("sb",   0, 1, 2'd0, 0, 32'h101, 32'h00000055, 1, 4'b0010, 32'h55555555, 32'h0, 0);
        do_req("lw2",  0, 0, 2'd2, 0, 32'h100, 32'h0, 1, 4'h0, 32'h0, 32'hDEAD55EF, 0);
        do_req("sw1",  1, 1, 2'd2, 0, 32'h104, 32'h12345678, 1, 4'hF, 32'h12345678, 32'h0, 0);
        do_req("sh1",  1, 1, 2'd1, 0, 32'h106, 32'h0000CAFE, 1, 4'b1100, 32'hCAFECAFE, 32'h0, 0);
        do_req("lw1",  1, 0, 2'd3, 0, 32'h104, 32'h0, 1, 4'h0, 32'h0, 32'hCAFE5678, 0);

        // Contention: both ports hold requests for four cycles
        set_req(0, 0, 2'd2, 0, 32'h100, 32'h0);
        set_req(1, 0, 2'd2, 0, 32'h104, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", {30'h0, gnts}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_mem_en", {31'h0, mem_en}, 32'h1);
            if (i % 2 == 0) push_exp(0, 32'hDEAD55EF, 0);
            else            push_exp(1, 32'hCAFE5678, 0);
            @(posedge clk); #1;
        end
        m0_if.req = 1'b0; m1_if.req = 1'b0;

        do_req("mis_lw", 1, 0, 2'd2, 0, 32'h102, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
        do_req("mis_sh", 1, 1, 2'd1, 0, 32'h103, 32'h0000BBBB, 0, 4'h0, 32'h0, 32'h0, 1);
        do_req("mis_rd", 1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 4'h0, 32'h0, 32'hDEAD55EF, 0);

        // Reset right after a contested grant: response dropped, pointer back to RR_INIT
        set_req(0, 0, 2'd2, 0, 32'h100, 32'h0);
        set_req(1, 0, 2'd2, 0, 32'h104, 32'h0);
        @(negedge clk);
        chk("pre_rst_gnt", {30'h0, gnts}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_drop_rvalid", {30'h0, m1_if.rvalid, m0_if.rvalid}, 32'h0);
        chk("rst_hold_gnt", {30'h0, gnts}, 32'h0);
        chk("rst_hold_mem_en", {31'h0, mem_en}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", {30'h0, gnts}, 32'h1);
        if (m0_if.gnt) push_exp(0, 32'hDEAD55EF, 0);
        @(posedge clk); #1;
        m0_if.req = 1'b0; m1_if.req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
